// File: rtl/op_seq_pkg.sv
// Shared types for the datapath command sequencer.
// Opcode, queued-command bundle and sequencer FSM states.
package op_seq_pkg;

  typedef logic [2:0] opcode_t;

  typedef struct packed {
    logic [7:0] data;
    opcode_t    op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

endpackage

// File: rtl/op_seq_fifo.sv
// Synchronous command FIFO for the sequencer.
// Pointers carry one extra wrap bit to tell full from empty.
module op_seq_fifo
  import op_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/op_cmd_sequencer.sv
// Queues host commands, drives them into the datapath, returns results.
// Define OP_SEQ_STATS_EN to build the issued-command counter.
module op_cmd_sequencer
  import op_seq_pkg::*;
#(
  parameter int            CMD_DEPTH = 4,
  parameter int            DP_LAT    = 1,
  parameter logic [2:0]    IDLE_OP   = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  dp_in,
  output logic [2:0]  dp_op,
  input  logic [7:0]  dp_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [2:0]  rsp_op,
  output logic [15:0] issue_cnt
);

  localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  state_t        state_q;
  state_t        state_d;
  cmd_t          head;
  cmd_t          cmd_in;
  logic          full;
  logic          empty;
  logic          pop;
  logic [CW-1:0] cnt_q;
  opcode_t       cur_op;

  assign cmd_ready = !full;
  assign cmd_in    = '{data: cmd_data, op: cmd_op};

  op_seq_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   if (cnt_q == '0) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dp_in stays put after the op window so a late-settling result is still valid
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in     <= '0;
      dp_op     <= IDLE_OP;
      cur_op    <= '0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            dp_in  <= head.data;
            dp_op  <= head.op;
            cur_op <= head.op;
            cnt_q  <= CW'(DP_LAT - 1);
          end
        end
        ISSUE: begin
          if (cnt_q == '0) dp_op <= IDLE_OP;
          else             cnt_q <= cnt_q - CW'(1);
        end
        CAPTURE: begin
          rsp_data  <= dp_out;
          rsp_op    <= cur_op;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef OP_SEQ_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst)      stat_q <= '0;
    else if (pop) stat_q <= stat_q + 16'd1;
  end

  assign issue_cnt = stat_q;
`else
  assign issue_cnt = 16'h0000;
`endif

endmodule
